fma_round_pack: RTL and testbench
=================================

// Module: fma_round_pack
// PURPOSE
//  Back end of the fma16 datapath: consumes the normalized sum (sign, biased exp, shifted mantissa, sticky)
//  from the add/normalize stage and rounds it to fp16, then packs the result with flags.
//  2-stage valid/ready pipeline between the add stage and the result writeback.
// PARAMETERS
//  NE  5   exponent width of the packed format
//  NF  10  fraction width of the packed format
// PORTS
//  clk             in   1        clock
//  reset           in   1        asynchronous, active-high reset
//  in_valid        in   1        upstream has an operation
//  in_ready        out  1        this block accepts this cycle
//  m_sign          in   1        sign of the normalized sum
//  m_exp           in   NE+2     biased exponent, two's complement
//  m_shifted       in   4*NF+6   normalized mantissa; leading 1 at bit 3*NF+2
//  a_sticky        in   1        sticky from alignment
//  sum_zero        in   1        the sum cancelled exactly to zero
//  special_valid   in   1        NaN/inf/invalid case already resolved upstream
//  special_result  in   NE+NF+1  packed value used when special_valid
//  special_invalid in   1        invalid flag for the special case
//  round_mode      in   2        00 RZ, 01 RNE, 10 RM (toward -inf), 11 RP (toward +inf)
//  out_valid       out  1        result available
//  out_ready       in   1        downstream takes the result
//  result          out  NE+NF+1  packed fp16 result
//  flags           out  4        {invalid, overflow, underflow, inexact}
//  flags_clr       in   1        clears flags_acc (FMA_FLAGS_ACC_EN only)
//  flags_acc       out  4        OR-accumulated flags (FMA_FLAGS_ACC_EN only)
// BEHAVIOUR
//  Reset: all stage valid bits = 0, out_valid = 0, result = 0, flags = 0, flags_acc = 0; in-flight ops are dropped.
//  Handshake:
//   - Transfer on in_valid&in_ready or out_valid&out_ready.
//   - in_ready = ~s1_valid | ~s2_valid | out_ready.
//   - s1 advances into s2 when s2 is empty or draining.
//   - Holds at most 2 ops; order is preserved; no bubbles under continuous ready.
//   - Outputs are stable while out_valid & ~out_ready.
//  Latency: exactly 2 cycles from accept to out_valid with out_ready=1; round_mode is sampled at accept.
//  Stage 1 (registered at accept), with F = m_shifted[3*NF+1:2*NF+2]:
//   - L = bit 2*NF+2; G = bit 2*NF+1; S = |m_shifted[2*NF:0] | a_sticky.
//   - rup: RZ = 0; RNE = G&(L|S); RM = m_sign&(G|S); RP = ~m_sign&(G|S).
//  Stage 2 (registered into output):
//   - {c, Fr} = {1'b0, F} + rup. If c is set, then e = m_exp+1 and Fr = 0; otherwise e = m_exp.
//   - Normal case (1 <= e <= 2^NE-2): result = {m_sign, e[NE-1:0], Fr}; inexact = G|S.
//   - Overflow (e >= 2^NE-1):
//       overflow = inexact = 1.
//       Result is inf (exp all ones, frac 0) for RNE, for RM with sign 1, and for RP with sign 0.
//       Otherwise result is maxnorm {sign, 2^NE-2, all ones}.
//   - Underflow (e <= 0, signed compare) and ~sum_zero: flush to signed zero {m_sign, 0}; underflow = inexact = 1.
//   - sum_zero: result = 0x0000 (+0); flags = 0.
//   - special_valid overrides everything: result = special_result; flags = {special_invalid, 3'b000}.
//  Simultaneous accept and drain in the same cycle is legal with a full pipe.
// CONFIGURATION
//  FMA_FLAGS_ACC_EN defined:
//   - flags_acc |= flags on every output transfer (out_valid&out_ready).
//   - flags_clr=1 clears flags_acc. If a transfer happens in the same cycle, flags_acc takes only that transfer's flags.
//  FMA_FLAGS_ACC_EN undefined: flags_acc is tied to 0 and flags_clr is ignored; no extra state.
// TESTING
//  1. m_exp=15, F=0, G=1, S=0, RNE -> 0x3C00, flags=0001; same stimulus with RP -> 0x3C01, flags=0001.
//  2. m_exp=15, F=0x3FF, G=1, RNE -> carry, 0x4000, inexact; with RZ -> 0x3FFF.
//  3. m_exp=30, F=0x3FF, G=1, RNE -> 0x7C00, flags=0101; RZ -> 0x7BFF; RM with sign 1 -> 0xFC00.
//  4. m_exp=0, sum_zero=0, sign=1 -> 0x8000, flags=0011; sum_zero=1 -> 0x0000, flags=0000.
//  5. special_valid=1, special_result=0x7E00, special_invalid=1 -> 0x7E00, flags=1000.
//  6. out_ready=0, 3 back-to-back ops -> 2 accepted, in_ready=0 while full; release -> results in order.
//     Reset asserted mid-flight -> out_valid=0 immediately; flags_acc = OR of delivered flags (when FMA_FLAGS_ACC_EN).

Source files
------------

// File: rtl/fma_round_pack.sv
// fma_round_pack: rounds the normalized fma16 sum to fp16 and packs result + flags.
// Latency: 2 cycles from accept to out_valid (stage 1 = round decision, stage 2 = pack).
// Backpressure: valid/ready skid of 2 ops; in_ready = ~s1_valid | ~s2_valid | out_ready.
// Optional build macro FMA_FLAGS_ACC_EN adds the sticky OR-accumulated flags_acc register.
module fma_round_pack #(
  parameter int NE = 5,
  parameter int NF = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              m_sign,
  input  logic [NE+1:0]     m_exp,
  input  logic [4*NF+5:0]   m_shifted,
  input  logic              a_sticky,
  input  logic              sum_zero,
  input  logic              special_valid,
  input  logic [NE+NF:0]    special_result,
  input  logic              special_invalid,
  input  logic [1:0]        round_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NE+NF:0]    result,
  output logic [3:0]        flags,
  input  logic              flags_clr,
  output logic [3:0]        flags_acc
);

  localparam logic [1:0] MODE_RZ  = 2'b00;
  localparam logic [1:0] MODE_RNE = 2'b01;
  localparam logic [1:0] MODE_RM  = 2'b10;
  localparam logic [1:0] MODE_RP  = 2'b11;

  // Exponent range limits, compared as signed values.
  localparam logic signed [NE+1:0] EXP_INF = (NE+2)'((1 << NE) - 1);
  localparam logic signed [NE+1:0] EXP_ONE = (NE+2)'(1);

  // Handshake state
  logic s1_valid;
  logic s2_valid;
  logic in_xfer;
  logic s1_adv;
  logic out_xfer;

  assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign s1_adv    = s1_valid & (~s2_valid | out_ready);
  assign out_xfer  = s2_valid & out_ready;
  assign out_valid = s2_valid;

  // Stage-1 rounding decision from the incoming mantissa
  logic [NF-1:0] in_frac;
  logic          in_l;
  logic          in_g;
  logic          in_s;
  logic          in_rup;

  assign in_frac = m_shifted[3*NF+1:2*NF+2];
  assign in_l    = m_shifted[2*NF+2];
  assign in_g    = m_shifted[2*NF+1];
  assign in_s    = (|m_shifted[2*NF:0]) | a_sticky;

  // Bits above the fraction (implicit one and headroom) carry no rounding information.
  logic unused_hi_bits;
  assign unused_hi_bits = ^m_shifted[4*NF+5:3*NF+2];

  // Round-up decision per rounding mode
  always_comb begin
    in_rup = 1'b0;
    case (round_mode)
      MODE_RZ:  in_rup = 1'b0;
      MODE_RNE: in_rup = in_g & (in_l | in_s);
      MODE_RM:  in_rup = m_sign & (in_g | in_s);
      MODE_RP:  in_rup = ~m_sign & (in_g | in_s);
      default:  in_rup = 1'b0;
    endcase
  end

  // Stage-1 registers
  logic                   s1_sign;
  logic signed [NE+1:0]   s1_exp;
  logic [NF-1:0]          s1_frac;
  logic                   s1_inexact;
  logic                   s1_rup;
  logic                   s1_zero;
  logic                   s1_spec_vld;
  logic [NE+NF:0]         s1_spec_res;
  logic                   s1_spec_inv;
  logic [1:0]             s1_mode;

  // Stage-1 valid tracks accepts and hand-offs to stage 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage-1 payload is captured on accept, round_mode included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_frac     <= '0;
      s1_inexact  <= 1'b0;
      s1_rup      <= 1'b0;
      s1_zero     <= 1'b0;
      s1_spec_vld <= 1'b0;
      s1_spec_res <= '0;
      s1_spec_inv <= 1'b0;
      s1_mode     <= MODE_RZ;
    end else if (in_xfer) begin
      s1_sign     <= m_sign;
      s1_exp      <= m_exp;
      s1_frac     <= in_frac;
      s1_inexact  <= in_g | in_s;
      s1_rup      <= in_rup;
      s1_zero     <= sum_zero;
      s1_spec_vld <= special_valid;
      s1_spec_res <= special_result;
      s1_spec_inv <= special_invalid;
      s1_mode     <= round_mode;
    end
  end

  // Stage-2 rounding increment; a fraction carry bumps the exponent
  logic [NF:0]          rnd_sum;
  logic signed [NE+1:0] rnd_exp;
  logic [NF-1:0]        rnd_frac;
  logic                 to_inf;

  assign rnd_sum  = {1'b0, s1_frac} + {{NF{1'b0}}, s1_rup};
  assign rnd_exp  = rnd_sum[NF] ? (s1_exp + EXP_ONE) : s1_exp;
  assign rnd_frac = rnd_sum[NF] ? '0 : rnd_sum[NF-1:0];
  assign to_inf   = (s1_mode == MODE_RNE) |
                    ((s1_mode == MODE_RM) &  s1_sign) |
                    ((s1_mode == MODE_RP) & ~s1_sign);

  logic [NE+NF:0] nxt_result;
  logic [3:0]     nxt_flags;

  // Pack result and flags; specials beat zero, which beats range handling
  always_comb begin
    nxt_result = {s1_sign, rnd_exp[NE-1:0], rnd_frac};
    nxt_flags  = {3'b000, s1_inexact};
    if (s1_spec_vld) begin
      nxt_result = s1_spec_res;
      nxt_flags  = {s1_spec_inv, 3'b000};
    end else if (s1_zero) begin
      nxt_result = '0;
      nxt_flags  = 4'b0000;
    end else if (rnd_exp >= EXP_INF) begin
      nxt_flags  = 4'b0101;
      if (to_inf) begin
        nxt_result = {s1_sign, {NE{1'b1}}, {NF{1'b0}}};
      end else begin
        nxt_result = {s1_sign, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
      end
    end else if (rnd_exp < EXP_ONE) begin
      nxt_result = {s1_sign, {(NE+NF){1'b0}}};
      nxt_flags  = 4'b0011;
    end
  end

  // Stage-2 valid and output registers; outputs hold while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      result   <= '0;
      flags    <= 4'b0000;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        result   <= nxt_result;
        flags    <= nxt_flags;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef FMA_FLAGS_ACC_EN
  // Sticky flag accumulator; a clear coinciding with a transfer keeps only that transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_acc <= 4'b0000;
    end else if (flags_clr) begin
      flags_acc <= out_xfer ? flags : 4'b0000;
    end else if (out_xfer) begin
      flags_acc <= flags_acc | flags;
    end
  end
`else
  assign flags_acc = 4'b0000;

  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
`endif

endmodule

// File: tb/tb_fma_round_pack.sv
// Bench for fma_round_pack: directed vectors with hand-computed results,
// checked by a queue-based scoreboard popped on each output transfer.
module tb_fma_round_pack;

  localparam logic [1:0] RZ  = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RM  = 2'b10;
  localparam logic [1:0] RP  = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        m_sign = 1'b0;
  logic [6:0]  m_exp = '0;
  logic [45:0] m_shifted = '0;
  logic        a_sticky = 1'b0;
  logic        sum_zero = 1'b0;
  logic        special_valid = 1'b0;
  logic [15:0] special_result = '0;
  logic        special_invalid = 1'b0;
  logic [1:0]  round_mode = RZ;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        flags_clr = 1'b0;
  logic [3:0]  flags_acc;

  fma_round_pack #(.NE(5), .NF(10)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .m_sign(m_sign), .m_exp(m_exp), .m_shifted(m_shifted), .a_sticky(a_sticky),
    .sum_zero(sum_zero), .special_valid(special_valid), .special_result(special_result),
    .special_invalid(special_invalid), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
    .flags_clr(flags_clr), .flags_acc(flags_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    string       tag;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] acc_model = 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] acc_expect();
`ifdef FMA_FLAGS_ACC_EN
    return acc_model;
`else
    return 4'b0000;
`endif
  endfunction

  // Monitor: a transfer happens at the posedge following a negedge with valid & ready.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output", result);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_result"}, {16'h0, result}, {16'h0, e.res});
        check({e.tag, "_flags"}, {28'h0, flags}, {28'h0, e.flg});
        acc_model = acc_model | e.flg;
      end
    end
  end

  // Hold in_valid until accepted, log the expectation at the accepting edge.
  task automatic issue(input string tag, input logic [15:0] eres, input logic [3:0] eflg);
    int waited;
    exp_t e;
    waited = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept: in_ready stayed 0, expected accept within 40 cycles", tag);
    end else begin
      e.res = eres; e.flg = eflg; e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic sg, input logic [6:0] ex,
                      input logic [9:0] fr, input logic g, input logic s, input logic stk,
                      input logic zero, input logic [1:0] mode,
                      input logic [15:0] eres, input logic [3:0] eflg);
    m_sign = sg;
    m_exp = ex;
    m_shifted = {13'b0, 1'b1, fr, g, 20'b0, s};
    a_sticky = stk;
    sum_zero = zero;
    special_valid = 1'b0;
    special_result = '0;
    special_invalid = 1'b0;
    round_mode = mode;
    issue(tag, eres, eflg);
  endtask

  task automatic send_special(input string tag, input logic [15:0] sres, input logic sinv,
                              input logic [15:0] eres, input logic [3:0] eflg);
    m_sign = 1'b0;
    m_exp = 7'd15;
    m_shifted = {13'b0, 1'b1, 32'h0};
    a_sticky = 1'b0;
    sum_zero = 1'b0;
    special_valid = 1'b1;
    special_result = sres;
    special_invalid = sinv;
    round_mode = RNE;
    issue(tag, eres, eflg);
    special_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d results outstanding, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_flags", {28'h0, flags}, 32'h0);
    check("rst_flags_acc", {28'h0, flags_acc}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Tie case plus latency: out_valid shows up two edges after the accepting edge
    send("t1_rne", 1'b0, 7'd15, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h3C00, 4'b0001);
    @(negedge clk);
    check("lat_one_edge", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("lat_two_edges", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors under continuous ready
    send("t1_rp",        1'b0, 7'd15, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'h3C01, 4'b0001);
    send("rne_sticky",   1'b0, 7'd15, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, RNE, 16'h3C01, 4'b0001);
    send("exact",        1'b0, 7'd15, 10'h155, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 16'h3D55, 4'b0000);
    send("t2_carry",     1'b0, 7'd15, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h4000, 4'b0001);
    send("t2_rz",        1'b0, 7'd15, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, RZ,  16'h3FFF, 4'b0001);
    send("t3_ovf_rne",   1'b0, 7'd30, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h7C00, 4'b0101);
    send("t3_rz",        1'b0, 7'd30, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, RZ,  16'h7BFF, 4'b0001);
    send("t3_rm_neg",    1'b1, 7'd30, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, RM,  16'hFC00, 4'b0101);
    send("ovf_rp_neg",   1'b1, 7'd31, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, RP,  16'hFBFF, 4'b0101);
    send("min_normal",   1'b0, 7'd1,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0, RZ,  16'h0400, 4'b0000);
    send("t4_uflow",     1'b1, 7'd0,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 16'h8000, 4'b0011);
    send("uflow_negexp", 1'b0, 7'h7D, 10'h123, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h0000, 4'b0011);
    send("t4_zero",      1'b1, 7'd0,  10'h000, 1'b0, 1'b0, 1'b0, 1'b1, RNE, 16'h0000, 4'b0000);
    send_special("t5_special", 16'h7E00, 1'b1, 16'h7E00, 4'b1000);
    wait_drain("batch1");
    @(negedge clk);
    check("acc_batch1", {28'h0, flags_acc}, {28'h0, acc_expect()});

    // Clear the accumulator with no transfer in flight
    @(posedge clk);
    #1;
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
    acc_model = 4'b0000;
    @(negedge clk);
    check("acc_cleared", {28'h0, flags_acc}, {28'h0, acc_expect()});
    @(posedge clk);
    #1;

    // Full pipe: two accepted, third held off until downstream is ready
    out_ready = 1'b0;
    send("bp_a", 1'b0, 7'd16, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0, RZ,  16'h4001, 4'b0000);
    send("bp_b", 1'b1, 7'd16, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, RZ,  16'hC000, 4'b0000);
    fork
      send("bp_c", 1'b0, 7'd14, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h3C00, 4'b0001);
      begin
        @(negedge clk);
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        check("full_out_valid", {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        check("full_in_ready_2", {31'h0, in_ready}, 32'h0);
        check("stall_hold", {16'h0, result}, 32'h4001);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("bp");
    @(negedge clk);
    check("acc_bp", {28'h0, flags_acc}, {28'h0, acc_expect()});

    // Reset with two ops in flight: they are dropped
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send("drop_d", 1'b0, 7'd30, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h7C00, 4'b0101);
    send("drop_e", 1'b0, 7'd15, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'h3C01, 4'b0001);
    reset = 1'b1;
    sb_q.delete();
    acc_model = 4'b0000;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("midrst_result", {16'h0, result}, 32'h0);
    check("midrst_flags", {28'h0, flags}, 32'h0);
    check("midrst_flags_acc", {28'h0, flags_acc}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Pipeline works again after reset
    send("post_rst", 1'b0, 7'd15, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, RP, 16'h3C01, 4'b0001);
    wait_drain("post_rst");
    @(negedge clk);
    check("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("acc_post_rst", {28'h0, flags_acc}, {28'h0, acc_expect()});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
